spike_rate_counter: RTL and testbench

SPIKE_RATE_COUNTER -- requirements
Module: spike_rate_counter

---
 rtl/rate_counter_pkg.sv | 21 ++
 rtl/spike_count_col.sv | 47 ++++
 rtl/spike_rate_counter.sv | 146 ++++++++++++++
 tb/tb_spike_rate_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_counter_pkg.sv
// Shared definitions for the spike-rate monitoring blocks: default widths,
// the rate-counter FSM state encoding and a column-index width helper.
package rate_counter_pkg;

    localparam int DEF_NUM_COLS  = 1;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_WIN_WIDTH = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DRAIN = 2'd2
    } rc_state_e;

    // Width of a column index; never below one bit so a single column still
    // has a real result-column port.
    function automatic int col_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_count_col.sv
// One neuron column: saturating on/off spike counters plus a sticky flag
// recording that a spike arrived while its counter was already full.
module spike_count_col
    import rate_counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic                 spike_valid,
    input  logic                 spike_on_off,
    output logic [CNT_WIDTH-1:0] on_cnt,
    output logic [CNT_WIDTH-1:0] off_cnt,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] on_q;
    logic [CNT_WIDTH-1:0] off_q;
    logic                 sat_q;

    // Count spikes by polarity while enabled; a full counter holds its value
    // and raises the sticky flag instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            on_q  <= '0;
            off_q <= '0;
            sat_q <= 1'b0;
        end else if (count_en && spike_valid) begin
            if (spike_on_off) begin
                if (on_q == CNT_MAX) sat_q <= 1'b1;
                else                 on_q  <= on_q + CNT_WIDTH'(1);
            end else begin
                if (off_q == CNT_MAX) sat_q <= 1'b1;
                else                  off_q <= off_q + CNT_WIDTH'(1);
            end
        end
    end

    assign on_cnt  = on_q;
    assign off_cnt = off_q;
    assign sat     = sat_q;

endmodule

// File: rtl/spike_rate_counter.sv
// Measures per-column on/off spike counts over a programmable window of clk
// cycles, then streams one result per column through a valid/ready port.
module spike_rate_counter
    import rate_counter_pkg::*;
#(
    parameter int NUM_COLS  = DEF_NUM_COLS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int WIN_WIDTH = DEF_WIN_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_COLS-1:0]                 spike_valid,
    input  logic [NUM_COLS-1:0]                 spike_on_off,
    input  logic [WIN_WIDTH-1:0]                window_len,
    input  logic                                start,
    input  logic                                stop,
    output logic                                busy,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [col_idx_width(NUM_COLS)-1:0]  res_col,
    output logic [CNT_WIDTH-1:0]                res_on_cnt,
    output logic [CNT_WIDTH-1:0]                res_off_cnt,
    output logic [WIN_WIDTH-1:0]                res_elapsed,
    output logic                                res_sat,
    output logic [1:0]                          dbg_state
);

    localparam int               COL_W    = col_idx_width(NUM_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    rc_state_e            state_q, state_d;
    logic [WIN_WIDTH-1:0] win_len_q, win_len_d;
    logic [WIN_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [WIN_WIDTH-1:0] elapsed_inc;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 busy_q;
    logic                 res_valid_q;
    logic                 clear_cols;
    logic                 count_en;

    logic [CNT_WIDTH-1:0] on_all  [NUM_COLS];
    logic [CNT_WIDTH-1:0] off_all [NUM_COLS];
    logic [NUM_COLS-1:0]  sat_all;

    assign elapsed_inc = elapsed_q + WIN_WIDTH'(1);

    // Result handshake: res_valid stays high for the whole DRAIN state and
    // the presented column is held until a cycle with res_valid && res_ready;
    // the following column appears on the very next cycle.

    // Next-state logic: window start, counted cycles, and column draining.
    always_comb begin
        state_d    = state_q;
        win_len_d  = win_len_q;
        elapsed_d  = elapsed_q;
        col_d      = col_q;
        clear_cols = 1'b0;
        count_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (window_len != '0)) begin
                    clear_cols = 1'b1;
                    win_len_d  = window_len;
                    elapsed_d  = '0;
                    col_d      = '0;
                    state_d    = ST_COUNT;
                end
            end
            ST_COUNT: begin
                count_en  = 1'b1;
                elapsed_d = elapsed_inc;
                if ((elapsed_inc == win_len_q) || stop) begin
                    col_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, window bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            win_len_q   <= '0;
            elapsed_q   <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_len_q   <= win_len_d;
            elapsed_q   <= elapsed_d;
            col_q       <= col_d;
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_DRAIN);
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
        spike_count_col #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_col (
            .clk          (clk),
            .reset        (reset),
            .clear        (clear_cols),
            .count_en     (count_en),
            .spike_valid  (spike_valid[g]),
            .spike_on_off (spike_on_off[g]),
            .on_cnt       (on_all[g]),
            .off_cnt      (off_all[g]),
            .sat          (sat_all[g])
        );
    end

    // Result mux: select the presented column; outputs read zero outside DRAIN.
    always_comb begin
        res_on_cnt  = '0;
        res_off_cnt = '0;
        res_sat     = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (res_valid_q && (col_q == COL_W'(c))) begin
                res_on_cnt  = on_all[c];
                res_off_cnt = off_all[c];
                res_sat     = sat_all[c];
            end
        end
        res_elapsed = res_valid_q ? elapsed_q : '0;
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_col   = col_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_rate_counter.sv
// Directed bench: two instances share all inputs, one with 16-bit counters
// and one with 4-bit counters, so saturation is exercised alongside the
// normal counts on every window.
module tb_spike_rate_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  spike_valid;
    logic [1:0]  spike_on_off;
    logic [19:0] window_len;
    logic        start;
    logic        stop;
    logic        res_ready;

    logic        busy_a, res_valid_a, res_col_a, res_sat_a;
    logic [15:0] res_on_a, res_off_a;
    logic [19:0] res_el_a;
    logic [1:0]  dbg_a;

    logic        busy_b, res_valid_b, res_col_b, res_sat_b;
    logic [3:0]  res_on_b, res_off_b;
    logic [19:0] res_el_b;
    logic [1:0]  dbg_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spike_rate_counter #(.NUM_COLS(2), .CNT_WIDTH(16), .WIN_WIDTH(20)) u_dut_a (
        .clk(clk), .reset(reset), .spike_valid(spike_valid), .spike_on_off(spike_on_off),
        .window_len(window_len), .start(start), .stop(stop), .busy(busy_a),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_col(res_col_a),
        .res_on_cnt(res_on_a), .res_off_cnt(res_off_a), .res_elapsed(res_el_a),
        .res_sat(res_sat_a), .dbg_state(dbg_a)
    );

    spike_rate_counter #(.NUM_COLS(2), .CNT_WIDTH(4), .WIN_WIDTH(20)) u_dut_b (
        .clk(clk), .reset(reset), .spike_valid(spike_valid), .spike_on_off(spike_on_off),
        .window_len(window_len), .start(start), .stop(stop), .busy(busy_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_col(res_col_b),
        .res_on_cnt(res_on_b), .res_off_cnt(res_off_b), .res_elapsed(res_el_b),
        .res_sat(res_sat_b), .dbg_state(dbg_b)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int col, input int on_a, input int off_a,
                           input int el, input int sat_a, input int on_b, input int off_b,
                           input int sat_b);
        chk({tag, ".valid_a"}, 32'(res_valid_a), 1);
        chk({tag, ".valid_b"}, 32'(res_valid_b), 1);
        chk({tag, ".col_a"},   32'(res_col_a), col);
        chk({tag, ".col_b"},   32'(res_col_b), col);
        chk({tag, ".on_a"},    32'(res_on_a), on_a);
        chk({tag, ".off_a"},   32'(res_off_a), off_a);
        chk({tag, ".el_a"},    32'(res_el_a), el);
        chk({tag, ".sat_a"},   32'(res_sat_a), sat_a);
        chk({tag, ".on_b"},    32'(res_on_b), on_b);
        chk({tag, ".off_b"},   32'(res_off_b), off_b);
        chk({tag, ".el_b"},    32'(res_el_b), el);
        chk({tag, ".sat_b"},   32'(res_sat_b), sat_b);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy_a"},  32'(busy_a), 0);
        chk({tag, ".busy_b"},  32'(busy_b), 0);
        chk({tag, ".valid_a"}, 32'(res_valid_a), 0);
        chk({tag, ".valid_b"}, 32'(res_valid_b), 0);
    endtask

    // Start a window; sv/oo are driven during the start cycle itself.
    task automatic start_win(input string tag, input int len, input logic [1:0] sv,
                             input logic [1:0] oo);
        window_len   = 20'(len);
        start        = 1'b1;
        spike_valid  = sv;
        spike_on_off = oo;
        step();
        start       = 1'b0;
        spike_valid = 2'b00;
        chk({tag, ".busy_a"},  32'(busy_a), 1);
        chk({tag, ".busy_b"},  32'(busy_b), 1);
        chk({tag, ".valid_a"}, 32'(res_valid_a), 0);
    endtask

    initial begin
        int seen;

        reset        = 1'b1;
        spike_valid  = 2'b00;
        spike_on_off = 2'b00;
        window_len   = '0;
        start        = 1'b0;
        stop         = 1'b0;
        res_ready    = 1'b0;
        step();
        step();
        step();
        chk_idle("reset");
        chk("reset.col_a", 32'(res_col_a), 0);
        chk("reset.on_a",  32'(res_on_a), 0);
        chk("reset.el_a",  32'(res_el_a), 0);
        chk("reset.sat_a", 32'(res_sat_a), 0);
        reset = 1'b0;
        step();

        // Window 100: col0 on every 10th cycle, col1 off every 4th cycle.
        start_win("w100", 100, 2'b00, 2'b00);
        for (int k = 0; k < 100; k++) begin
            spike_valid  = {(k % 4) == 0, (k % 10) == 0};
            spike_on_off = 2'b01;
            step();
        end
        spike_valid = 2'b00;
        chk_res("w100.c0", 0, 10, 0, 100, 0, 10, 0, 0);
        res_ready = 1'b1;
        step();
        chk_res("w100.c1", 1, 0, 25, 100, 0, 0, 15, 1);
        step();
        res_ready = 1'b0;
        chk_idle("w100.end");

        // Window 1000 stopped at counted cycle 300, col0 on every cycle.
        start_win("stop", 1000, 2'b00, 2'b00);
        for (int k = 0; k < 300; k++) begin
            spike_valid  = 2'b01;
            spike_on_off = 2'b01;
            stop         = (k == 299);
            step();
        end
        spike_valid = 2'b00;
        stop        = 1'b0;
        chk_res("stop.c0", 0, 300, 0, 300, 0, 15, 0, 1);
        res_ready = 1'b1;
        step();
        chk_res("stop.c1", 1, 0, 0, 300, 0, 0, 0, 0);
        step();
        res_ready = 1'b0;
        chk_idle("stop.end");

        // Window 40, col0 on every cycle: 4-bit instance saturates at 15.
        start_win("sat", 40, 2'b00, 2'b00);
        for (int k = 0; k < 40; k++) begin
            spike_valid  = 2'b01;
            spike_on_off = 2'b01;
            step();
        end
        spike_valid = 2'b00;
        chk_res("sat.c0", 0, 40, 0, 40, 0, 15, 0, 1);
        res_ready = 1'b1;
        step();
        chk_res("sat.c1", 1, 0, 0, 40, 0, 0, 0, 0);
        step();
        res_ready = 1'b0;
        chk_idle("sat.end");

        // Window 5 then a 5-cycle backpressure stall on col0; spikes during DRAIN are dropped.
        start_win("bp", 5, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) begin
            spike_valid  = {k == 1, (k == 0) || (k == 2)};
            spike_on_off = 2'b01;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            spike_valid  = 2'b11;
            spike_on_off = 2'b01;
            chk_res("bp.hold", 0, 2, 0, 5, 0, 2, 0, 0);
            step();
        end
        spike_valid = 2'b00;
        chk_res("bp.hold6", 0, 2, 0, 5, 0, 2, 0, 0);
        res_ready = 1'b1;
        step();
        chk_res("bp.c1", 1, 0, 1, 5, 0, 0, 1, 0);
        chk("bp.c1.busy", 32'(busy_a), 1);
        step();
        res_ready = 1'b0;
        chk_idle("bp.end");

        // Reset at counted cycle 50 of a 100-cycle window, with start in the same cycle.
        start_win("rst", 100, 2'b00, 2'b00);
        for (int k = 0; k < 49; k++) begin
            spike_valid  = 2'b01;
            spike_on_off = 2'b01;
            step();
        end
        reset       = 1'b1;
        start       = 1'b1;
        window_len  = 20'd10;
        spike_valid = 2'b01;
        step();
        reset       = 1'b0;
        start       = 1'b0;
        spike_valid = 2'b00;
        chk_idle("rst.after");
        chk("rst.on_a", 32'(res_on_a), 0);
        chk("rst.el_a", 32'(res_el_a), 0);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (res_valid_a || res_valid_b || busy_a) seen++;
            step();
        end
        chk("rst.no_result", 32'(seen), 0);

        // Fresh 10-cycle window after the reset: exactly three spikes.
        start_win("post", 10, 2'b00, 2'b00);
        for (int k = 0; k < 10; k++) begin
            spike_valid  = {k == 3, (k == 1) || (k == 5)};
            spike_on_off = {1'b1, k == 1};
            step();
        end
        spike_valid = 2'b00;
        chk_res("post.c0", 0, 1, 1, 10, 0, 1, 1, 0);
        res_ready = 1'b1;
        step();
        chk_res("post.c1", 1, 1, 0, 10, 0, 1, 0, 0);
        step();
        res_ready = 1'b0;
        chk_idle("post.end");

        // Ignored requests: zero-length start, stop in IDLE, start in COUNT and DRAIN.
        window_len = 20'd0;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk_idle("zero_len");
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("idle_stop");
        start_win("ign", 20, 2'b01, 2'b01);
        for (int k = 0; k < 20; k++) begin
            spike_valid  = {k == 10, 1'b0};
            spike_on_off = 2'b00;
            start        = (k == 5);
            window_len   = (k == 5) ? 20'd3 : 20'd20;
            step();
        end
        spike_valid = 2'b00;
        start       = 1'b0;
        chk_res("ign.c0", 0, 0, 0, 20, 0, 0, 0, 0);
        start      = 1'b1;
        window_len = 20'd7;
        step();
        start = 1'b0;
        chk_res("ign.drain_start", 0, 0, 0, 20, 0, 0, 0, 0);
        res_ready = 1'b1;
        step();
        chk_res("ign.c1", 1, 0, 1, 20, 0, 0, 1, 0);
        step();
        res_ready = 1'b0;
        chk_idle("ign.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
